// File: rtl/sconfig_tx.sv
// -----------------------------------------------------------------------------
// sconfig_tx
//
// Serial configuration transmitter for the backend startup receiver. On an
// accepted start it latches an N_BITS gain word and shifts it out MSB first on
// the o_sclk/o_sdin pair. After the last bit it waits for the backend's ready
// flag and reports either completion (o_done pulse) or a timeout (sticky
// o_timeout).
//
// Every output is a flop. Each next value is decided in the same cycle as the
// state transition, so there is no combinational path from any input to any
// output.
//
// Parameters
//   N_BITS         frame length in bits (gain word {gainA1[2:0],gainA2[1:0]})
//   DIV            i_clk cycles per sclk half-period, 2..255
//   READY_TIMEOUT  i_clk cycles to wait for i_ready after the last bit, 1..65535
//
// Ports
//   i_clk        system clock; all logic runs on the rising edge
//   i_resetbAll  asynchronous active-low reset
//   i_start      frame request; only sampled in IDLE
//   i_data       word to send; latched when i_start is accepted
//   i_ready      backend ready flag, synchronous to i_clk
//   o_sclk       serial clock; idles low
//   o_sdin       serial data; changes only while o_sclk is low
//   o_busy       high while a frame or the ready wait is in progress
//   o_done       one-cycle pulse: i_ready seen before the timeout
//   o_timeout    sticky timeout flag; cleared by the next accepted i_start
//   o_dbg_state  current FSM state, for debug and checker binding
//
// Handshake: i_start is a level request. It is accepted only on a rising edge
// where the FSM is in IDLE. While a frame is running, i_start is ignored and
// nothing is queued. i_ready is only looked at in WAIT_RDY.
// -----------------------------------------------------------------------------
module sconfig_tx #(
    parameter int N_BITS        = 5,
    parameter int DIV           = 4,
    parameter int READY_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_resetbAll,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_data,
    input  logic              i_ready,
    output logic              o_sclk,
    output logic              o_sdin,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic [2:0]        o_dbg_state
);

    localparam int DCW = $clog2(DIV + 1);
    localparam int BCW = $clog2(N_BITS + 1);

    // Terminal counts. Each counter starts at zero on entry to its phase, so
    // the phase ends when the counter reaches length-1.
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(N_BITS - 1);
    localparam logic [15:0]    TMO_LAST = 16'(READY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOW      = 3'd1,
        S_HIGH     = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_DONE     = 3'd4,
        S_FAIL     = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [DCW-1:0]    div_cnt_q, div_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [N_BITS-1:0] shreg_q, shreg_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic              sclk_q, sclk_d;
    logic              sdin_q, sdin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    // Shift register after the current bit has gone out. Its MSB is the next
    // bit to present. A plain shift keeps this valid for N_BITS == 1 as well.
    logic [N_BITS-1:0] shreg_next;
    assign shreg_next = shreg_q << 1;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tmo_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdin_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tmo_cnt_q <= tmo_cnt_d;
            sclk_q    <= sclk_d;
            sdin_q    <= sdin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and next registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tmo_cnt_d = tmo_cnt_q;
        sclk_d    = sclk_q;
        sdin_d    = sdin_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_LOW;
                    shreg_d   = i_data;
                    sdin_d    = i_data[N_BITS-1];
                    sclk_d    = 1'b0;
                    busy_d    = 1'b1;
                    timeout_d = 1'b0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end

            S_LOW: begin
                // The data bit was set up on entry to LOW. Only the clock
                // changes at the end of this phase, so sdin never moves on a
                // rising sclk edge.
                if (div_cnt_q == DIV_LAST) begin
                    state_d   = S_HIGH;
                    sclk_d    = 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
            end

            S_HIGH: begin
                if (div_cnt_q == DIV_LAST) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = '0;
                    shreg_d   = shreg_next;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        // Last falling edge: park the data line low and start
                        // the ready wait.
                        state_d   = S_WAIT_RDY;
                        sdin_d    = 1'b0;
                        tmo_cnt_d = '0;
                    end else begin
                        // The next bit goes out together with the falling edge.
                        state_d = S_LOW;
                        sdin_d  = shreg_next[N_BITS-1];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
            end

            S_WAIT_RDY: begin
                // i_ready wins over an expiring timeout in the same cycle.
                if (i_ready) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = S_FAIL;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAIL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_sclk      = sclk_q;
    assign o_sdin      = sdin_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sconfig_tx.sv
// Bench for sconfig_tx. Two instances share one clock and one reset:
// dut_a uses DIV=4 and READY_TIMEOUT=8, and dut_b uses DIV=2 and
// READY_TIMEOUT=20. For every i_clk cycle of a frame, the expected waveform is
// computed from the frame timing rules with plain arithmetic. A simple receiver
// also recovers the word from the sclk rising edges.
module tb_sconfig_tx;

  localparam int NB = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic [NB-1:0] data_in = '0;
  bit use_b = 1'b0;

  int checks = 0;
  int errors = 0;
  bit last_tmo[2];

  always #5 clk = ~clk;

  logic a_start, a_ready, b_start, b_ready;
  assign a_start = start & ~use_b;
  assign a_ready = ready & ~use_b;
  assign b_start = start & use_b;
  assign b_ready = ready & use_b;

  logic a_sclk, a_sdin, a_busy, a_done, a_tmo;
  logic b_sclk, b_sdin, b_busy, b_done, b_tmo;
  logic [2:0] a_dbg, b_dbg;

  sconfig_tx #(.N_BITS(NB), .DIV(4), .READY_TIMEOUT(8)) dut_a (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(a_start), .i_data(data_in),
    .i_ready(a_ready), .o_sclk(a_sclk), .o_sdin(a_sdin), .o_busy(a_busy),
    .o_done(a_done), .o_timeout(a_tmo), .o_dbg_state(a_dbg)
  );

  sconfig_tx #(.N_BITS(NB), .DIV(2), .READY_TIMEOUT(20)) dut_b (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(b_start), .i_data(data_in),
    .i_ready(b_ready), .o_sclk(b_sclk), .o_sdin(b_sdin), .o_busy(b_busy),
    .o_done(b_done), .o_timeout(b_tmo), .o_dbg_state(b_dbg)
  );

  logic obs_sclk, obs_sdin, obs_busy, obs_done, obs_tmo;
  always_comb begin
    obs_sclk = use_b ? b_sclk : a_sclk;
    obs_sdin = use_b ? b_sdin : a_sdin;
    obs_busy = use_b ? b_busy : a_busy;
    obs_done = use_b ? b_done : a_done;
    obs_tmo  = use_b ? b_tmo  : a_tmo;
  end

  typedef struct packed {
    logic sclk;
    logic sdin;
    logic busy;
    logic done;
    logic tmo;
  } exp_t;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs after rising edge t. Edge 1 is the edge that accepts
  // i_start. Bit k occupies edges 1+2*div*k .. 2*div*(k+1): low for div
  // cycles, then high for div cycles. Edge f is the last falling edge, and the
  // frame ends at edge e.
  function automatic exp_t model(input int t, input logic [NB-1:0] data, input int div,
                                 input int f, input int e, input bit tmo_frame);
    exp_t r;
    r = '0;
    if (t < f) begin
      r.sclk = (((t - 1) % (2 * div)) >= div);
      r.sdin = data[NB - 1 - (t - 1) / (2 * div)];
      r.busy = 1'b1;
    end else if (t < e) begin
      r.busy = 1'b1;
    end else if (t == e) begin
      r.done = ~tmo_frame;
      r.tmo  = tmo_frame;
    end else begin
      r.tmo = tmo_frame;
    end
    return r;
  endfunction

  // rdy_d: ready is driven after edge f+rdy_d (a negative value drives it
  // before the wait starts). Any value with rdy_d+1 > timeout gives a timeout
  // frame. rst_at: apply reset after edge rst_at (0 means no reset).
  task automatic run_frame(input bit b, input logic [NB-1:0] data, input int rdy_d,
                           input bit strays, input bit hold, input int rst_at);
    int div, rt, f, e;
    bit tmo_frame;
    exp_t ex;
    logic [NB-1:0] cap;
    int rises;
    logic prev;
    div = b ? 2 : 4;
    rt  = b ? 20 : 8;
    f   = 1 + 2 * div * NB;
    tmo_frame = (rdy_d + 1 > rt);
    e = tmo_frame ? f + rt : f + ((rdy_d > 0) ? rdy_d : 0) + 1;
    use_b = b;
    cap = '0;
    rises = 0;
    prev = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("idle_tmo", obs_tmo, last_tmo[b]);
    check("idle_busy", obs_busy, 0);
    data_in = data;
    start = 1'b1;
    for (int t = 1; t <= e + 3; t++) begin
      @(posedge clk);
      #1;
      if (t == 1 && !hold) start = 1'b0;
      if (t == 2) data_in = NB'($urandom);
      if (strays && (t == 3 || t == 20)) start = 1'b1;
      if (strays && (t == 4 || t == 21)) start = 1'b0;
      if (!tmo_frame && t == f + rdy_d) ready = 1'b1;
      if (t == e) ready = 1'b0;
      @(negedge clk);
      if (hold && t == e + 2) begin
        check($sformatf("hold_busy t=%0d", t), obs_busy, 1);
        check($sformatf("hold_sclk t=%0d", t), obs_sclk, 0);
        check($sformatf("hold_sdin t=%0d", t), obs_sdin, data_in[NB-1]);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_tmo[0] = 1'b0;
        last_tmo[1] = 1'b0;
        return;
      end
      ex = model(t, data, div, f, e, tmo_frame);
      check($sformatf("sclk t=%0d", t), obs_sclk, ex.sclk);
      check($sformatf("sdin t=%0d", t), obs_sdin, ex.sdin);
      check($sformatf("busy t=%0d", t), obs_busy, ex.busy);
      check($sformatf("done t=%0d", t), obs_done, ex.done);
      check($sformatf("timeout t=%0d", t), obs_tmo, ex.tmo);
      if (obs_sclk && !prev) begin
        cap = {cap[NB-2:0], obs_sdin};
        rises++;
      end
      prev = obs_sclk;
      if (rst_at == t) begin
        rst_n = 1'b0;
        #1;
        check("rst_sclk", obs_sclk, 0);
        check("rst_sdin", obs_sdin, 0);
        check("rst_busy", obs_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_tmo[0] = 1'b0;
        last_tmo[1] = 1'b0;
        return;
      end
    end
    check("sclk_rises", rises, NB);
    check("rx_word", cap, data);
    last_tmo[b] = tmo_frame;
  endtask

  initial begin
    last_tmo[0] = 1'b0;
    last_tmo[1] = 1'b0;

    // Reset values of both instances.
    repeat (3) @(negedge clk);
    check("rst_a_sclk", a_sclk, 0);
    check("rst_a_sdin", a_sdin, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_tmo", a_tmo, 0);
    check("rst_b_sclk", b_sclk, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_tmo", b_tmo, 0);
    rst_n = 1'b1;

    // Directed frames.
    run_frame(1'b0, 5'b10110, 2, 1'b0, 1'b0, 0);     // basic frame, ready answered
    run_frame(1'b0, 5'b00111, 100, 1'b0, 1'b0, 0);   // no ready: timeout
    run_frame(1'b0, 5'b11100, 3, 1'b0, 1'b0, 0);     // sticky timeout cleared by start
    run_frame(1'b0, 5'b01011, 1, 1'b1, 1'b0, 0);     // stray starts ignored
    run_frame(1'b0, 5'b11001, 0, 1'b0, 1'b0, 14);    // reset while sclk is high
    run_frame(1'b0, 5'b10110, 4, 1'b0, 1'b0, 0);     // full frame after reset
    run_frame(1'b1, 5'b01101, 2, 1'b0, 1'b0, 0);     // DIV=2 instance
    run_frame(1'b0, 5'b10011, -1, 1'b0, 1'b0, 0);    // ready already high on entry
    run_frame(1'b0, 5'b01110, 7, 1'b0, 1'b0, 0);     // ready on the last legal cycle
    run_frame(1'b0, 5'b10001, 8, 1'b0, 1'b0, 0);     // one cycle too late: timeout
    run_frame(1'b0, 5'b11010, 3, 1'b0, 1'b1, 0);     // start held high: restart

    // Random frames on both instances, some of them timing out.
    for (int i = 0; i < 10; i++) begin
      bit b;
      b = bit'($urandom_range(0, 1));
      run_frame(b, NB'($urandom), int'($urandom_range(0, b ? 24 : 10)), 1'b0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
